hilo_muldiv_seq: RTL

Multi-cycle sequencer for the MIPS HI/LO unit: executes MULT, MULTU, DIV, DIVU iteratively and MTHI/MTLO directly, holding the HI and LO architectural registers. Sits beside the ALU in the execute stage. The instruction decoder drives it with a start strobe plus operation code. It returns a stall that freezes the PC and instruction fetch while a HI/LO consumer or new HI/LO producer meets an in-flight operation.

---
 rtl/hilo_muldiv_seq.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_seq.sv
// Iterative HI/LO sequencer: shift-add MULT/MULTU, restoring DIV/DIVU, direct MTHI/MTLO.
// Optional macro HILO_FAST_MULT_EN swaps the multiply loop for a single-cycle 32x32 multiplier.
//
// state | meaning
// IDLE  | accepts work; MTHI/MTLO write here
// RUN   | one multiply/divide bit per cycle, counter counts down from 32
// FIX   | sign fix-up and HI/LO write, done_o follows
module hilo_muldiv_seq #(
    parameter int ITER_W = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic        mf_req_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy_o,
    output logic        stall_o,
    output logic        done_o,
    output logic        dz_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [1:0] K_MUL = 2'd0;
    localparam logic [1:0] K_DIV = 2'd1;
    localparam logic [1:0] K_RAW = 2'd2;

    logic [1:0]        state_q;
    logic [ITER_W-1:0] cnt_q;
    logic [63:0]       acc_q;
    logic [31:0]       rem_q;
    logic [31:0]       opb_q;
    logic [1:0]        kind_q;
    logic              neg_res_q;
    logic              neg_rem_q;
    logic [31:0]       hi_q;
    logic [31:0]       lo_q;
    logic              done_q;
    logic              dz_q;

    logic        op_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_take;
    logic [63:0] prod_fixed;
    logic [31:0] quot_fixed;
    logic [31:0] rem_fixed;
`ifdef HILO_FAST_MULT_EN
    logic [63:0] fast_prod;
`endif

    // Signed ops work on magnitudes; 0x80000000 negates to itself, which is the right unsigned magnitude.
    always_comb begin
        op_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
        a_neg     = op_signed & rs_data_i[31];
        b_neg     = op_signed & rt_data_i[31];
        a_mag     = a_neg ? (32'd0 - rs_data_i) : rs_data_i;
        b_mag     = b_neg ? (32'd0 - rt_data_i) : rt_data_i;
    end

`ifdef HILO_FAST_MULT_EN
    assign fast_prod = {32'd0, a_mag} * {32'd0, b_mag};
`endif

    // Multiply: acc = {partial, multiplier}; add multiplicand into the top half, shift right.
    // Divide: acc[31:0] shifts the dividend out and the quotient in from the bottom.
    always_comb begin
        mul_sum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        div_shift  = {rem_q, acc_q[31]};
        div_diff   = div_shift - {1'b0, opb_q};
        div_take   = ~div_diff[32];
        prod_fixed = neg_res_q ? (64'd0 - acc_q) : acc_q;
        quot_fixed = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        rem_fixed  = neg_rem_q ? (32'd0 - rem_q) : rem_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            opb_q     <= '0;
            kind_q    <= K_MUL;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        case (op_i)
                            OP_MULT, OP_MULTU: begin
                                dz_q      <= 1'b0;
                                kind_q    <= K_MUL;
                                neg_res_q <= a_neg ^ b_neg;
                                neg_rem_q <= 1'b0;
`ifdef HILO_FAST_MULT_EN
                                acc_q     <= fast_prod;
                                cnt_q     <= '0;
                                state_q   <= FIX;
`else
                                acc_q     <= {32'd0, b_mag};
                                opb_q     <= a_mag;
                                cnt_q     <= ITER_W'(32);
                                state_q   <= RUN;
`endif
                            end
                            OP_DIV, OP_DIVU: begin
                                if (rt_data_i == 32'd0) begin
                                    dz_q    <= 1'b1;
                                    kind_q  <= K_RAW;
                                    acc_q   <= {rs_data_i, 32'hFFFF_FFFF};
                                    state_q <= FIX;
                                end else begin
                                    dz_q      <= 1'b0;
                                    kind_q    <= K_DIV;
                                    acc_q     <= {32'd0, a_mag};
                                    rem_q     <= '0;
                                    opb_q     <= b_mag;
                                    neg_res_q <= a_neg ^ b_neg;
                                    neg_rem_q <= a_neg;
                                    cnt_q     <= ITER_W'(32);
                                    state_q   <= RUN;
                                end
                            end
                            OP_MTHI: hi_q <= rs_data_i;
                            OP_MTLO: lo_q <= rs_data_i;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - ITER_W'(1);
                    if (kind_q == K_DIV) begin
                        rem_q        <= div_take ? div_diff[31:0] : div_shift[31:0];
                        acc_q[31:0]  <= {acc_q[30:0], div_take};
                    end else begin
                        acc_q <= {mul_sum, acc_q[31:1]};
                    end
                    if (cnt_q == ITER_W'(1))
                        state_q <= FIX;
                end
                FIX: begin
                    case (kind_q)
                        K_MUL: begin
                            hi_q <= prod_fixed[63:32];
                            lo_q <= prod_fixed[31:0];
                        end
                        K_DIV: begin
                            hi_q <= rem_fixed;
                            lo_q <= quot_fixed;
                        end
                        default: begin
                            hi_q <= acc_q[63:32];
                            lo_q <= acc_q[31:0];
                        end
                    endcase
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign busy_o  = (state_q != IDLE);
    assign stall_o = busy_o & (start_i | mf_req_i);
    assign done_o  = done_q;
    assign dz_o    = dz_q;

endmodule
